// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared definitions for the 8-bit CPU.
// Holds the opcode constants used by the control unit and the ALU, the control
// FSM state encoding, the ALU operand-source encodings and the is_long() decode helper.
package cpu8_pkg;

  // Opcodes occupy bits [7:4] of the instruction byte.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDO = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_LDR = 4'd3;
  localparam logic [3:0] OP_PRE = 4'd4;
  localparam logic [3:0] OP_STO = 4'd5;
  localparam logic [3:0] OP_ADD = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SAR = 4'd9;
  localparam logic [3:0] OP_INV = 4'd10;
  localparam logic [3:0] OP_AND = 4'd11;
  localparam logic [3:0] OP_OR  = 4'd12;
  localparam logic [3:0] OP_XOR = 4'd13;
  localparam logic [3:0] OP_JMP = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // ALU operand-source mux encodings.
  typedef logic [1:0] alu_src_t;
  localparam alu_src_t SRC_OPR = 2'd0;
  localparam alu_src_t SRC_RAM = 2'd1;
  localparam alu_src_t SRC_REG = 2'd2;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPER   = 3'd3,
    ST_MEM    = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Long opcodes carry one operand byte at PC+1.
  function automatic logic is_long(input logic [3:0] op);
    return (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: bus between the control unit and ROM / RAM / ALU datapath.
// master = control unit (drives address, strobes, ALU controls); slave = datapath side
// (drives run, ROM data and ALU flags). ADDR_W sets the program-address width.
interface cpu_ctrl_if #(
  parameter int ADDR_W = 8
);
  import cpu8_pkg::*;

  logic              run;
  logic [7:0]        instr;
  logic [3:0]        flags;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        alu_op;
  alu_src_t          alu_src;
  logic              acc_we;
  logic              reg_we;
  logic [7:0]        ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [7:0]        operand;
  logic              halted;
  logic [3:0]        flags_q;

  modport master (
    input  run, instr, flags,
    output rom_addr, alu_op, alu_src, acc_we, reg_we,
           ram_addr, ram_re, ram_we, operand, halted, flags_q
  );

  modport slave (
    output run, instr, flags,
    input  rom_addr, alu_op, alu_src, acc_we, reg_we,
           ram_addr, ram_re, ram_we, operand, halted, flags_q
  );

endinterface

// File: rtl/cpu_pc.sv
// cpu_pc: program counter register with load (priority) and increment.
// Ports: clk, rst_n (async active-low), i_inc, i_load, i_load_val -> o_pc.
// Increment wraps modulo 2^ADDR_W.
module cpu_pc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit; fetch, decode and sequence the accumulator datapath.
// Ports: clk, rst_n (async active-low), bus (cpu_ctrl_if.master: run/instr/flags in,
// ROM/RAM address, strobes, ALU controls, operand, halted, flags_q out).
// Optional macro CPU_CTRL_FLAGS_EN: latch ALU flags on acc_we; otherwise flags_q = 0.
module cpu_ctrl
  import cpu8_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  cpu_ctrl_if.master bus
);

  state_t            r_state;
  state_t            w_nxt;
  logic [3:0]        r_ir;
  logic [7:0]        r_operand;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_jmp_tgt;

  logic              w_ir_ld;
  logic              w_opr_ld;
  logic              w_pc_inc;
  logic              w_pc_load;
  alu_src_t          w_alu_src;
  logic              w_acc_we;
  logic              w_reg_we;
  logic              w_ram_re;
  logic              w_ram_we;

  // Size cast truncates or zero-extends the 8-bit operand to the PC width.
  assign w_jmp_tgt = ADDR_W'(r_operand);

  cpu_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_pc_inc),
    .i_load     (w_pc_load),
    .i_load_val (w_jmp_tgt),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_operand <= '0;
    end else begin
      if (w_ir_ld)  r_ir      <= bus.instr[7:4];
      if (w_opr_ld) r_operand <= bus.instr;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_ir_ld   = 1'b0;
    w_opr_ld  = 1'b0;
    w_pc_inc  = 1'b0;
    w_pc_load = 1'b0;
    w_alu_src = SRC_OPR;
    w_acc_we  = 1'b0;
    w_reg_we  = 1'b0;
    w_ram_re  = 1'b0;
    w_ram_we  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.run) w_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_ir_ld  = 1'b1;
        w_pc_inc = 1'b1;
        w_nxt    = ST_DECODE;
      end
      ST_DECODE: begin
        if (r_ir == OP_HLT)   w_nxt = ST_HALT;
        else if (is_long(r_ir)) w_nxt = ST_OPER;
        else                  w_nxt = ST_EXEC;
      end
      ST_OPER: begin
        w_opr_ld = 1'b1;
        w_pc_inc = 1'b1;
        w_nxt    = (r_ir == OP_LDA) ? ST_MEM : ST_EXEC;
      end
      ST_MEM: begin
        w_ram_re = 1'b1;
        w_nxt    = ST_EXEC;
      end
      ST_EXEC: begin
        // run is only sampled here, so an instruction always completes.
        w_nxt = bus.run ? ST_FETCH : ST_IDLE;
        case (r_ir)
          OP_LDO: begin
            w_alu_src = SRC_OPR;
            w_acc_we  = 1'b1;
          end
          OP_LDA: begin
            w_alu_src = SRC_RAM;
            w_acc_we  = 1'b1;
          end
          OP_LDR: w_reg_we = 1'b1;
          OP_STO: w_ram_we = 1'b1;
          OP_PRE, OP_ADD, OP_SHL, OP_SHR, OP_SAR,
          OP_INV, OP_AND, OP_OR, OP_XOR: begin
            w_alu_src = SRC_REG;
            w_acc_we  = 1'b1;
          end
          OP_JMP: w_pc_load = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: w_nxt = ST_HALT;
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign bus.rom_addr = w_pc;
  assign bus.alu_op   = r_ir;
  assign bus.alu_src  = w_alu_src;
  assign bus.acc_we   = w_acc_we;
  assign bus.reg_we   = w_reg_we;
  assign bus.ram_re   = w_ram_re;
  assign bus.ram_we   = w_ram_we;
  assign bus.ram_addr = r_operand;
  assign bus.operand  = r_operand;
  assign bus.halted   = (r_state == ST_HALT);

`ifdef CPU_CTRL_FLAGS_EN
  logic [3:0] r_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags_q <= '0;
    end else if (w_acc_we) begin
      r_flags_q <= bus.flags;
    end
  end

  assign bus.flags_q = r_flags_q;
`else
  logic [3:0] w_unused_flags;
  assign w_unused_flags = bus.flags;
  assign bus.flags_q    = 4'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed-vector bench for cpu_ctrl with a combinational ROM array.
// Drives run/instr/flags through cpu_ctrl_if, samples outputs on the falling edge.
// flags come from a tiny ALU stand-in so flags_q latching can be observed.
module tb_cpu_ctrl;

  logic clk;
  logic rst_n;
  logic [7:0] rom [256];
  int n_chk;
  int n_fail;
  int cyc;

  cpu_ctrl_if #(.ADDR_W(8)) bus ();

  cpu_ctrl #(.ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] w_res;
  logic [3:0] w_strb;
  assign bus.instr = rom[bus.rom_addr];
  assign w_res     = (bus.alu_src == 2'd0) ? bus.operand : 8'hFF;
  assign bus.flags = {1'b0, (w_res == 8'h00), w_res[7], 1'b0};
  assign w_strb    = {bus.acc_we, bus.reg_we, bus.ram_re, bus.ram_we};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic hold_rst();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic release_rst(input logic run_v);
    bus.run = run_v;
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  int wes;
  logic [3:0] strb_or;
  logic halt_all;

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    bus.run = 1'b0;

    // LDO 0x5A from reset, including reset-state checks
    hold_rst();
    rom[0] = 8'h10; rom[1] = 8'h5A;
    bus.run = 1'b1;
    @(negedge clk);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    chk("rst_operand", 32'(bus.operand), 0);
    chk("rst_strobes", 32'(w_strb), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_alu_src", 32'(bus.alu_src), 0);
    chk("rst_flags_q", 32'(bus.flags_q), 0);
    rst_n = 1'b1;
    cyc = 0;
    upto(1);
    chk("ldo_c1_rom_addr", 32'(bus.rom_addr), 0);
    chk("ldo_c1_strobes", 32'(w_strb), 0);
    upto(2);
    chk("ldo_c2_alu_op", 32'(bus.alu_op), 1);
    chk("ldo_c2_rom_addr", 32'(bus.rom_addr), 1);
    upto(3);
    chk("ldo_c3_acc_we", 32'(bus.acc_we), 0);
    upto(4);
    chk("ldo_c4_acc_we", 32'(bus.acc_we), 1);
    chk("ldo_c4_alu_src", 32'(bus.alu_src), 0);
    chk("ldo_c4_operand", 32'(bus.operand), 32'h5A);
    upto(5);
    chk("ldo_c5_rom_addr", 32'(bus.rom_addr), 2);
    chk("ldo_c5_acc_we", 32'(bus.acc_we), 0);

    // LDO 0x00 -> ZF latched when the flags option is built in
    hold_rst();
    rom[0] = 8'h10; rom[1] = 8'h00;
    release_rst(1'b1);
    upto(3);
    chk("flg_c3_flags_q", 32'(bus.flags_q), 0);
    upto(4);
    chk("flg_c4_acc_we", 32'(bus.acc_we), 1);
    upto(5);
`ifdef CPU_CTRL_FLAGS_EN
    chk("flg_c5_flags_q", 32'(bus.flags_q), 4);
`else
    chk("flg_c5_flags_q", 32'(bus.flags_q), 0);
`endif

    // LDA 0x33
    hold_rst();
    rom[0] = 8'h20; rom[1] = 8'h33;
    release_rst(1'b1);
    chk("lda_rst_flags_q", 32'(bus.flags_q), 0);
    upto(3);
    chk("lda_c3_ram_re", 32'(bus.ram_re), 0);
    upto(4);
    chk("lda_c4_ram_re", 32'(bus.ram_re), 1);
    chk("lda_c4_ram_addr", 32'(bus.ram_addr), 32'h33);
    chk("lda_c4_acc_we", 32'(bus.acc_we), 0);
    upto(5);
    chk("lda_c5_acc_we", 32'(bus.acc_we), 1);
    chk("lda_c5_alu_src", 32'(bus.alu_src), 1);
    chk("lda_c5_ram_re", 32'(bus.ram_re), 0);
    upto(6);
    chk("lda_c6_rom_addr", 32'(bus.rom_addr), 2);

    // STO 0x80 then ADD
    hold_rst();
    rom[0] = 8'h50; rom[1] = 8'h80; rom[2] = 8'h60;
    release_rst(1'b1);
    wes = 0;
    for (int c = 1; c <= 8; c++) begin
      upto(c);
      if (bus.ram_we) wes++;
      if (c == 4) begin
        chk("sto_c4_ram_we", 32'(bus.ram_we), 1);
        chk("sto_c4_ram_addr", 32'(bus.ram_addr), 32'h80);
      end
      if (c == 5) chk("add_c5_rom_addr", 32'(bus.rom_addr), 2);
      if (c == 6) chk("add_c6_acc_we", 32'(bus.acc_we), 0);
      if (c == 7) begin
        chk("add_c7_acc_we", 32'(bus.acc_we), 1);
        chk("add_c7_alu_src", 32'(bus.alu_src), 2);
      end
    end
    chk("sto_we_count", 32'(wes), 1);

    // JMP 0xFE at 0, then JMP 0x00 at 0xFE with operand at 0xFF
    hold_rst();
    rom[0] = 8'hE0; rom[1] = 8'hFE; rom[8'hFE] = 8'hE0; rom[8'hFF] = 8'h00;
    release_rst(1'b1);
    upto(4);
    chk("jmp_c4_rom_addr", 32'(bus.rom_addr), 2);
    chk("jmp_c4_strobes", 32'(w_strb), 0);
    upto(5);
    chk("jmp_c5_rom_addr", 32'(bus.rom_addr), 32'hFE);
    upto(6);
    chk("jmp_c6_rom_addr", 32'(bus.rom_addr), 32'hFF);
    upto(8);
    chk("jmp_c8_rom_addr", 32'(bus.rom_addr), 0);
    upto(9);
    chk("jmp_c9_rom_addr", 32'(bus.rom_addr), 0);
    upto(10);
    chk("jmp_c10_rom_addr", 32'(bus.rom_addr), 1);

    // NOP at 0xFF wraps the PC to 0
    hold_rst();
    rom[0] = 8'hE0; rom[1] = 8'hFF; rom[8'hFF] = 8'h00;
    release_rst(1'b1);
    upto(5);
    chk("nop_c5_rom_addr", 32'(bus.rom_addr), 32'hFF);
    upto(6);
    chk("nop_c6_rom_addr", 32'(bus.rom_addr), 0);
    upto(7);
    chk("nop_c7_strobes", 32'(w_strb), 0);
    upto(8);
    chk("nop_c8_rom_addr", 32'(bus.rom_addr), 0);
    upto(9);
    chk("nop_c9_rom_addr", 32'(bus.rom_addr), 1);

    // run dropped during DECODE of ADD
    hold_rst();
    rom[0] = 8'h60; rom[1] = 8'h60; rom[2] = 8'h60;
    release_rst(1'b1);
    upto(2);
    bus.run = 1'b0;
    upto(3);
    chk("pause_c3_acc_we", 32'(bus.acc_we), 1);
    upto(4);
    chk("pause_c4_rom_addr", 32'(bus.rom_addr), 1);
    upto(5);
    chk("pause_c5_rom_addr", 32'(bus.rom_addr), 1);
    chk("pause_c5_strobes", 32'(w_strb), 0);
    bus.run = 1'b1;
    upto(6);
    chk("resume_c6_rom_addr", 32'(bus.rom_addr), 1);
    upto(7);
    chk("resume_c7_rom_addr", 32'(bus.rom_addr), 2);
    upto(8);
    chk("resume_c8_acc_we", 32'(bus.acc_we), 1);

    // HLT: terminal, run ignored
    hold_rst();
    rom[0] = 8'hF0;
    release_rst(1'b1);
    upto(2);
    chk("hlt_c2_halted", 32'(bus.halted), 0);
    upto(3);
    chk("hlt_c3_halted", 32'(bus.halted), 1);
    strb_or = 4'b0;
    halt_all = 1'b1;
    for (int c = 4; c <= 12; c++) begin
      bus.run = c[0];
      upto(c);
      strb_or = strb_or | w_strb;
      halt_all = halt_all & bus.halted;
    end
    chk("hlt_strobes", 32'(strb_or), 0);
    chk("hlt_halted_held", 32'(halt_all), 1);
    chk("hlt_rom_addr", 32'(bus.rom_addr), 1);

    // reset pulse during MEM of LDA
    hold_rst();
    rom[0] = 8'h20; rom[1] = 8'h33;
    release_rst(1'b1);
    upto(4);
    chk("rmem_c4_ram_re", 32'(bus.ram_re), 1);
    rst_n = 1'b0;
    #1;
    chk("rmem_ram_re", 32'(bus.ram_re), 0);
    chk("rmem_rom_addr", 32'(bus.rom_addr), 0);
    chk("rmem_operand", 32'(bus.operand), 0);
    chk("rmem_alu_op", 32'(bus.alu_op), 0);
    @(negedge clk);
    chk("rmem_acc_we", 32'(bus.acc_we), 0);
    rst_n = 1'b1;
    cyc = 0;
    upto(1);
    chk("rmem_c1_rom_addr", 32'(bus.rom_addr), 0);
    chk("rmem_c1_strobes", 32'(w_strb), 0);
    upto(2);
    chk("rmem_c2_alu_op", 32'(bus.alu_op), 2);
    chk("rmem_c2_rom_addr", 32'(bus.rom_addr), 1);
    upto(5);
    chk("rmem_c5_acc_we", 32'(bus.acc_we), 1);
    chk("rmem_c5_alu_src", 32'(bus.alu_src), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
